// File: rtl/timer_peripheral.sv
// rtl/timer_peripheral.sv - memory-mapped down-counting timer with prescaler and level interrupt
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR      = 32'h40000000,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] data_out,
    output logic        interrupt
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_STATUS   = 3'd1;
    localparam logic [2:0] IDX_LOAD     = 3'd2;
    localparam logic [2:0] IDX_VALUE    = 3'd3;
    localparam logic [2:0] IDX_PRESCALE = 3'd4;

    state_t                      state_q, state_d;
    logic                        periodic_q, irq_en_q;
    logic                        pending_q, overrun_q;
    logic [31:0]                 load_q, value_q;
    logic [PRESCALE_WIDTH-1:0]   prescale_q, pcnt_q;

    logic       sel, mapped;
    logic [2:0] idx;
    logic       wr_ctrl, wr_status, wr_load, wr_prescale;
    logic       running, tick, expire, start;

    assign sel    = (addr[31:12] == BASE_ADDR[31:12]);
    assign idx    = addr[4:2];
    assign mapped = sel && (addr[11:5] == 7'd0);

    assign wr_ctrl     = write_enable && mapped && (idx == IDX_CTRL);
    assign wr_status   = write_enable && mapped && (idx == IDX_STATUS);
    assign wr_load     = write_enable && mapped && (idx == IDX_LOAD);
    assign wr_prescale = write_enable && mapped && (idx == IDX_PRESCALE);

    assign running = (state_q == RUNNING);
    assign tick    = running && (pcnt_q == prescale_q);
    // A LOAD write in the same cycle suppresses both decrement and expiry.
    assign expire  = tick && !wr_load && (value_q == 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            STOPPED: begin
                if (wr_ctrl && data_in[0]) begin
                    state_d = RUNNING;
                    start   = 1'b1;
                end
            end
            RUNNING: begin
                if (wr_ctrl) begin
                    state_d = data_in[0] ? RUNNING : STOPPED;
                end else if (expire && !periodic_q) begin
                    state_d = STOPPED;
                end
            end
            default: state_d = STOPPED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            load_q     <= 32'd0;
            value_q    <= 32'd0;
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            if (wr_ctrl) begin
                periodic_q <= data_in[1];
                irq_en_q   <= data_in[2];
            end
            if (wr_prescale) begin
                prescale_q <= data_in[PRESCALE_WIDTH-1:0];
            end
            if (wr_load) begin
                load_q <= data_in;
            end

            if (wr_load || start) begin
                pcnt_q <= '0;
            end else if (running) begin
                pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
            end

            if (wr_load) begin
                value_q <= data_in;
            end else if (tick) begin
                if (value_q != 32'd0) begin
                    value_q <= value_q - 32'd1;
                end else if (periodic_q) begin
                    value_q <= load_q;
                end
            end

            // Expiry takes precedence over a software clear in the same cycle.
            if (expire) begin
                pending_q <= 1'b1;
            end else if (wr_status && data_in[0]) begin
                pending_q <= 1'b0;
            end
            if (expire && pending_q) begin
                overrun_q <= 1'b1;
            end else if (wr_status && data_in[1]) begin
                overrun_q <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out = 32'd0;
        if (read_enable && mapped) begin
            case (idx)
                IDX_CTRL:     data_out = {29'd0, irq_en_q, periodic_q, running};
                IDX_STATUS:   data_out = {30'd0, overrun_q, pending_q};
                IDX_LOAD:     data_out = load_q;
                IDX_VALUE:    data_out = value_q;
                IDX_PRESCALE: data_out = 32'(prescale_q);
                default:      data_out = 32'd0;
            endcase
        end
    end

    assign interrupt = pending_q && irq_en_q;

endmodule

// File: tb/tb_timer_peripheral.sv
// tb/tb_timer_peripheral.sv - directed self-checking bench for timer_peripheral
module tb_timer_peripheral;

    localparam logic [31:0] A_CTRL     = 32'h40000000;
    localparam logic [31:0] A_STATUS   = 32'h40000004;
    localparam logic [31:0] A_LOAD     = 32'h40000008;
    localparam logic [31:0] A_VALUE    = 32'h4000000C;
    localparam logic [31:0] A_PRESCALE = 32'h40000010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] data_out;
    logic        interrupt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          c1, c2, wait_n;
    logic [31:0] rd;

    timer_peripheral #(
        .BASE_ADDR      (32'h40000000),
        .PRESCALE_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .addr         (addr),
        .data_in      (data_in),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_out     (data_out),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; data_in = d; write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; read_enable = 1'b1;
        #1;
        d = data_out;
        read_enable = 1'b0;
    endtask

    // Read within the current cycle without waiting for a clock edge.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a; read_enable = 1'b1;
        #1;
        d = data_out;
        read_enable = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; addr = 32'd0; data_in = 32'd0;
        write_enable = 1'b0; read_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_irq", {31'd0, interrupt}, 32'd0);
        check("reset_dout", data_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        bus_read(A_CTRL, rd);     check("rst_ctrl", rd, 32'd0);
        bus_read(A_STATUS, rd);   check("rst_status", rd, 32'd0);
        bus_read(A_LOAD, rd);     check("rst_load", rd, 32'd0);
        bus_read(A_VALUE, rd);    check("rst_value", rd, 32'd0);
        bus_read(A_PRESCALE, rd); check("rst_prescale", rd, 32'd0);

        // Unmapped offset, foreign window, and bad addr[11:5] alias
        bus_write(A_LOAD, 32'h0000_1234);
        bus_read(32'h40000014, rd); check("unmapped_14", rd, 32'd0);
        bus_read(32'h50000000, rd); check("foreign_win", rd, 32'd0);
        bus_read(32'h40000108, rd); check("alias_read", rd, 32'd0);
        bus_write(32'h40000108, 32'hDEAD_BEEF);
        bus_read(A_LOAD, rd);       check("alias_write_ignored", rd, 32'h0000_1234);

        // Simultaneous read/write returns pre-write data
        @(negedge clk);
        addr = A_LOAD; data_in = 32'h0000_5678; write_enable = 1'b1; read_enable = 1'b1;
        #1;
        check("rw_prewrite", data_out, 32'h0000_1234);
        @(posedge clk);
        #1;
        write_enable = 1'b0; read_enable = 1'b0;
        bus_read(A_LOAD, rd);       check("rw_postwrite", rd, 32'h0000_5678);

        // One-shot: LOAD=4, PRESCALE=0 -> expiry on 5th edge after CTRL write
        bus_write(A_LOAD, 32'd4);
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_CTRL, 32'h5);
        repeat (4) @(posedge clk);
        #1;
        check("oneshot_edge4_irq", {31'd0, interrupt}, 32'd0);
        @(posedge clk);
        #1;
        check("oneshot_edge5_irq", {31'd0, interrupt}, 32'd1);
        bus_read(A_CTRL, rd);   check("oneshot_ctrl", rd, 32'h4);
        bus_read(A_VALUE, rd);  check("oneshot_value", rd, 32'd0);
        bus_write(A_STATUS, 32'h1);
        check("oneshot_clear_irq", {31'd0, interrupt}, 32'd0);

        // Periodic: LOAD=2, PRESCALE=3 -> ticks every 4 cycles, expiry every 12
        bus_write(A_PRESCALE, 32'd3);
        bus_write(A_LOAD, 32'd2);
        bus_write(A_CTRL, 32'h7);
        addr = A_VALUE; read_enable = 1'b1;
        #1;
        check("per_value_t0", data_out, 32'd2);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 4)  check("per_value_t1", data_out, 32'd1);
            if (k == 8)  check("per_value_t2", data_out, 32'd0);
            if (k == 11) check("per_irq_before", {31'd0, interrupt}, 32'd0);
            if (k == 12) begin
                check("per_value_reload", data_out, 32'd2);
                check("per_irq_expiry", {31'd0, interrupt}, 32'd1);
            end
        end
        c1 = cyc;
        read_enable = 1'b0;
        bus_write(A_STATUS, 32'h1);
        wait_n = 0;
        while (!interrupt && wait_n < 60) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        c2 = cyc;
        check("per_interval", c2 - c1, 32'd12);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h3);

        // Overrun: periodic LOAD=1, PRESCALE=0, no clear
        bus_write(A_LOAD, 32'd1);
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_CTRL, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        peek(A_STATUS, rd);     check("ovr_after_first", rd, 32'h1);
        @(posedge clk);
        #1;
        peek(A_STATUS, rd);     check("ovr_after_second", rd, 32'h3);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h2);
        bus_read(A_STATUS, rd); check("ovr_cleared", rd, 32'h1);
        bus_write(A_STATUS, 32'h3);

        // Clear collides with expiry: pending must survive
        bus_write(A_LOAD, 32'd3);
        bus_write(A_CTRL, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        bus_write(A_STATUS, 32'h1);
        peek(A_STATUS, rd);     check("clr_vs_expiry", rd, 32'h1);
        peek(A_VALUE, rd);      check("clr_vs_expiry_reload", rd, 32'd3);

        // LOAD write on a tick cycle (PRESCALE=0 ticks every cycle)
        bus_write(A_LOAD, 32'd9);
        peek(A_VALUE, rd);      check("load_vs_tick", rd, 32'd9);
        @(posedge clk);
        #1;
        peek(A_VALUE, rd);      check("load_then_dec", rd, 32'd8);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h3);

        // Masking: irq_en=0 through expiry, then enable
        bus_write(A_LOAD, 32'd1);
        bus_write(A_CTRL, 32'h3);
        repeat (2) @(posedge clk);
        #1;
        check("mask_irq_low", {31'd0, interrupt}, 32'd0);
        peek(A_STATUS, rd);     check("mask_pending", rd, 32'h1);
        bus_write(A_CTRL, 32'h7);
        check("unmask_irq_high", {31'd0, interrupt}, 32'd1);
        bus_write(A_CTRL, 32'h3);
        check("remask_irq_low", {31'd0, interrupt}, 32'd0);
        peek(A_STATUS, rd);     check("remask_pending_kept", rd & 32'h1, 32'h1);

        // Asynchronous reset mid-count with interrupt asserted
        bus_write(A_LOAD, 32'd100);
        bus_write(A_CTRL, 32'h5);
        check("pre_reset_irq", {31'd0, interrupt}, 32'd1);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_irq", {31'd0, interrupt}, 32'd0);
        peek(A_VALUE, rd);      check("async_reset_value", rd, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(A_CTRL, rd);   check("post_reset_ctrl", rd, 32'd0);
        bus_read(A_LOAD, rd);   check("post_reset_load", rd, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_no_irq", {31'd0, interrupt}, 32'd0);
        bus_read(A_STATUS, rd); check("post_reset_status", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_peripheral.md
Name: timer_peripheral

Overview:
Memory-mapped down-counting timer. It is the responder on the CPU's simple memory bus (addr / data / write_enable / read_enable) and the source of the CPU's `interrupt` input. It decodes its own address window and services register reads and writes. On expiry it raises a level interrupt, which stays high until software writes 1 to the clear register at base+4.

Parameters:
- BASE_ADDR, 32'h40000000, base of 4 KB window; matched against addr[31:12].
- PRESCALE_WIDTH, 16, width of prescaler register and counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- addr  input  32  bus address from CPU.
- data_in  input  32  write data from CPU.
- write_enable  input  1  write strobe; one write per cycle while high.
- read_enable  input  1  read strobe.
- data_out  output  32  read data; combinational from addr/read_enable/registers.
- interrupt  output  1  level interrupt to CPU = pending & CTRL.irq_en.

Behaviour:
- Select: sel = (addr[31:12] == BASE_ADDR[31:12]). Register index = addr[4:2]; addr[11:5] must be 0, otherwise the access is unmapped.
- Register map (offset / access / contents):
  - 0x00 CTRL, RW: bit0 enable, bit1 periodic, bit2 irq_en; other bits read 0.
  - 0x04 STATUS/CLEAR: read {30'b0, overrun, pending}; write 1 to bit0 clears pending, write 1 to bit1 clears overrun.
  - 0x08 LOAD, RW.
  - 0x0C VALUE, RO: current count.
  - 0x10 PRESCALE, RW, low PRESCALE_WIDTH bits.
  - Unmapped offsets read 0; writes to them are ignored.
- Reads: data_out valid in the same cycle read_enable & sel is high (zero wait states; the CPU samples at the end of that cycle). data_out = 0 when not (read_enable & sel). Reads have no side effects.
- Writes: take effect at the rising edge where write_enable & sel is high. If read_enable and write_enable are both high, the write is performed and data_out still reflects the pre-write value.
- Reset values: all registers and counters 0; state STOPPED; interrupt = 0; data_out = 0.
- State machine:
  - STOPPED → RUNNING on a CTRL write with bit0 = 1. The prescale counter is cleared on entry.
  - RUNNING → STOPPED on a CTRL write with bit0 = 0, or on expiry when periodic = 0 (hardware also clears CTRL.enable).
  - VALUE holds in STOPPED.
- Prescaler: in RUNNING, pcnt increments each cycle. When pcnt == PRESCALE, pcnt wraps to 0 and a tick is generated.
- Tick handling:
  - If VALUE != 0: VALUE decrements.
  - If VALUE == 0: expiry. pending is set; if pending was already 1, overrun is also set. VALUE reloads from LOAD (periodic) or stays 0 (one-shot).
  - Period = (LOAD+1)*(PRESCALE+1) cycles.
- LOAD write: also copies data_in into VALUE and clears pcnt, in any state. If it coincides with a tick, the LOAD write wins and no decrement or expiry occurs that cycle.
- Simultaneous clear and expiry in the same cycle: expiry wins, so pending stays 1. The same rule applies to overrun.
- Starting with VALUE == 0: expiry occurs on the first tick.
- interrupt is a registered-state function, glitch-free, and follows irq_en immediately; clearing irq_en masks it without clearing pending.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronous). No expiry occurs after release until the timer is reprogrammed.

Test Plan:
- Reset and bus-read defaults:
  - Assert reset_n = 0 mid-count, then release → all registers read 0, interrupt = 0.
  - Read 0x40000014 and 0x50000000 → data_out = 0.
- One-shot expiry:
  - Write LOAD = 4, PRESCALE = 0, then CTRL = 0x5 → pending sets on the 5th rising edge after the CTRL write edge, and interrupt goes high.
  - CTRL then reads 0x4 and VALUE reads 0.
  - Write 0x1 to 0x40000004 → interrupt low next cycle.
- Periodic with prescale:
  - LOAD = 2, PRESCALE = 3, CTRL = 0x7; clear pending after each expiry → expiries exactly 12 cycles apart; VALUE sequence 2,1,0,2 at tick boundaries.
- Overrun:
  - Periodic LOAD = 1, PRESCALE = 0, no clear → STATUS reads 0x3 after the second expiry.
  - Write 0x2 → STATUS reads 0x1.
- Collisions:
  - Clear write on the exact expiry cycle → pending remains 1.
  - LOAD write on a tick cycle → VALUE equals the new LOAD with no decrement.
- Masking: CTRL = 0x3 (irq_en = 0) through an expiry → interrupt stays 0 and STATUS.pending = 1; then set irq_en → interrupt goes high immediately.
